// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, stall polarity, load_op codes, the MEM register layout and FSM states.
package mem_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int EX_TO_MEM_WD = 75;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_MEM    = 3;
  localparam int STALL_WB     = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  load_op;
    logic [1:0]  addr_lo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  // Codes 6 and 7 are reserved and fall through as non-loads.
  function automatic logic is_load(input logic [2:0] op);
    return (op >= LD_LB) && (op <= LD_LW);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational little-endian byte/half/word extraction with sign or zero extension.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfword loads ignore addr_lo[0]; misalignment is not trapped here.
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    data = word;
    case (load_op)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'h0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline register + load FSM, outputs one cycle after capture; holds on stall and
// raises stallreq_mem while a load waits for data. Optional MEM_WDT_EN adds a sticky WAIT watchdog.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WDT_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic                    data_sram_rvalid,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_fwd,
  output logic                    stallreq_mem,
  output logic                    mem_wdt_err
);

  ex_to_mem_t ex_in;
  ex_to_mem_t ex_q;
  mem_state_t state;
  mem_state_t state_nxt;
  logic [31:0] load_buf;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        bubble;
  logic        capture;
  logic        waiting;
  logic        rf_we;
  logic        unused_stall;

  assign ex_in        = ex_to_mem_bus;
  assign bubble       = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
  assign capture      = (stall[STALL_MEM] == NO_STOP);
  assign unused_stall = ^{stall[5], stall[2:0]};

  always_comb begin
    state_nxt = state;
    if (bubble)
      state_nxt = ST_IDLE;
    else if (capture)
      state_nxt = is_load(ex_in.load_op) ? ST_WAIT : ST_IDLE;
    else if ((state == ST_WAIT) && data_sram_rvalid)
      state_nxt = ST_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      state    <= ST_IDLE;
      load_buf <= '0;
    end else begin
      state <= state_nxt;
      if (bubble)
        ex_q <= '0;
      else if (capture)
        ex_q <= ex_in;
      if ((state == ST_WAIT) && data_sram_rvalid)
        load_buf <= data_sram_rdata;
    end
  end

  // Same-cycle rvalid bypasses load_buf so the stall drops with no extra latency.
  assign waiting      = (state == ST_WAIT) && !data_sram_rvalid;
  assign stallreq_mem = waiting;
  assign load_word    = (state == ST_WAIT) ? data_sram_rdata : load_buf;

  mem_load_align u_align (
    .load_op (ex_q.load_op),
    .addr_lo (ex_q.addr_lo),
    .word    (load_word),
    .data    (load_data)
  );

  assign rf_we    = ex_q.rf_we && !waiting;
  assign rf_wdata = is_load(ex_q.load_op) ? load_data : ex_q.ex_result;

  assign mem_to_wb_bus = {ex_q.pc, rf_we, ex_q.rf_waddr, rf_wdata};
  assign mem_to_id_fwd = {rf_we, ex_q.rf_waddr, rf_wdata};

`ifdef MEM_WDT_EN
  localparam int WDT_CW = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT + 1) : 1;

  logic [WDT_CW-1:0] wdt_cnt;
  logic              wdt_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (wdt_cnt != WDT_CW'(WDT_LIMIT))
        wdt_cnt <= wdt_cnt + WDT_CW'(1);
      if (wdt_cnt == WDT_CW'(WDT_LIMIT - 1))
        wdt_err <= 1'b1;
    end else begin
      wdt_cnt <= '0;
    end
  end

  assign mem_wdt_err = wdt_err;
`else
  logic [31:0] unused_wdt_limit;
  assign unused_wdt_limit = WDT_LIMIT;
  assign mem_wdt_err      = 1'b0;
`endif

endmodule
